// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter: shares the single-port mem_data RAM between the
// pipeline MEM stage (p_*) and the board debug reader (d_*).
// Ports: arb_in_clk/arb_in_rst (async, active-high); per requester a
// req/addr (and wren/data for writes) input and a gnt/valid/q output;
// arb_out_mem_* drive the RAM, arb_in_mem_q returns its registered q.
// Optional macro ARB_DEBUG_WRITE_EN adds arb_in_d_wren/arb_in_d_data.
// Read: IDLE/RESP -> ISSUE -> WAIT -> RESP. Write: IDLE/RESP -> ISSUE -> IDLE.
module mem_data_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              arb_in_clk,
    input  logic              arb_in_rst,
    input  logic              arb_in_p_req,
    input  logic              arb_in_p_wren,
    input  logic [ADDR_W-1:0] arb_in_p_addr,
    input  logic [DATA_W-1:0] arb_in_p_data,
    output logic              arb_out_p_gnt,
    output logic              arb_out_p_valid,
    output logic [DATA_W-1:0] arb_out_p_q,
    input  logic              arb_in_d_req,
    input  logic [ADDR_W-1:0] arb_in_d_addr,
`ifdef ARB_DEBUG_WRITE_EN
    input  logic              arb_in_d_wren,
    input  logic [DATA_W-1:0] arb_in_d_data,
`endif
    output logic              arb_out_d_gnt,
    output logic              arb_out_d_valid,
    output logic [DATA_W-1:0] arb_out_d_q,
    output logic [ADDR_W-1:0] arb_out_mem_address,
    output logic [DATA_W-1:0] arb_out_mem_data,
    output logic              arb_out_mem_wren,
    input  logic [DATA_W-1:0] arb_in_mem_q
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt, cnt_nxt;
    // owner of the access in flight: 1 = debug, 0 = pipeline
    logic              owner_d, owner_nxt;
    logic              p_gnt_nxt, d_gnt_nxt;
    logic              p_valid_nxt, d_valid_nxt;
    logic [DATA_W-1:0] p_q_nxt, d_q_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              wren_nxt;
    logic              p_win, d_win;
    logic              d_wr;
    logic [DATA_W-1:0] d_wdata;

`ifdef ARB_DEBUG_WRITE_EN
    assign d_wr    = arb_in_d_wren;
    assign d_wdata = arb_in_d_data;
`else
    assign d_wr    = 1'b0;
    assign d_wdata = '0;
`endif

    // Debug overrides the pipeline only once it has been passed over
    // STARVE_MAX times in a row.
    assign p_win = arb_in_p_req &&
                   !(arb_in_d_req && (starve_cnt == STARVE_LIM));
    assign d_win = arb_in_d_req && !p_win;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = starve_cnt;
        owner_nxt   = owner_d;
        p_gnt_nxt   = 1'b0;
        d_gnt_nxt   = 1'b0;
        p_valid_nxt = 1'b0;
        d_valid_nxt = 1'b0;
        p_q_nxt     = arb_out_p_q;
        d_q_nxt     = arb_out_d_q;
        addr_nxt    = arb_out_mem_address;
        data_nxt    = arb_out_mem_data;
        wren_nxt    = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                if (p_win) begin
                    state_nxt = ISSUE;
                    owner_nxt = 1'b0;
                    p_gnt_nxt = 1'b1;
                    addr_nxt  = arb_in_p_addr;
                    wren_nxt  = arb_in_p_wren;
                    if (arb_in_p_wren)
                        data_nxt = arb_in_p_data;
                    if (arb_in_d_req && (starve_cnt != STARVE_LIM))
                        cnt_nxt = starve_cnt + 1'b1;
                end else if (d_win) begin
                    state_nxt = ISSUE;
                    owner_nxt = 1'b1;
                    d_gnt_nxt = 1'b1;
                    addr_nxt  = arb_in_d_addr;
                    wren_nxt  = d_wr;
                    if (d_wr)
                        data_nxt = d_wdata;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            // mem_wren is only ever high in ISSUE, so it marks a write
            ISSUE: state_nxt = arb_out_mem_wren ? IDLE : WAIT;
            WAIT: begin
                state_nxt = RESP;
                if (owner_d) begin
                    d_q_nxt     = arb_in_mem_q;
                    d_valid_nxt = 1'b1;
                end else begin
                    p_q_nxt     = arb_in_mem_q;
                    p_valid_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge arb_in_clk or posedge arb_in_rst) begin
        if (arb_in_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge arb_in_clk or posedge arb_in_rst) begin
        if (arb_in_rst) begin
            starve_cnt          <= '0;
            owner_d             <= 1'b0;
            arb_out_p_gnt       <= 1'b0;
            arb_out_d_gnt       <= 1'b0;
            arb_out_p_valid     <= 1'b0;
            arb_out_d_valid     <= 1'b0;
            arb_out_p_q         <= '0;
            arb_out_d_q         <= '0;
            arb_out_mem_address <= '0;
            arb_out_mem_data    <= '0;
            arb_out_mem_wren    <= 1'b0;
        end else begin
            starve_cnt          <= cnt_nxt;
            owner_d             <= owner_nxt;
            arb_out_p_gnt       <= p_gnt_nxt;
            arb_out_d_gnt       <= d_gnt_nxt;
            arb_out_p_valid     <= p_valid_nxt;
            arb_out_d_valid     <= d_valid_nxt;
            arb_out_p_q         <= p_q_nxt;
            arb_out_d_q         <= d_q_nxt;
            arb_out_mem_address <= addr_nxt;
            arb_out_mem_data    <= data_nxt;
            arb_out_mem_wren    <= wren_nxt;
        end
    end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb_mem_data_arbiter: directed bench for mem_data_arbiter with a
// registered-output RAM model attached to the arbiter's memory port.
module tb_mem_data_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_req = 1'b0;
    logic        p_wren = 1'b0;
    logic [9:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic        p_gnt, p_valid;
    logic [31:0] p_q;
    logic        d_req = 1'b0;
    logic [9:0]  d_addr = '0;
`ifdef ARB_DEBUG_WRITE_EN
    logic        d_wren = 1'b0;
    logic [31:0] d_data = '0;
`endif
    logic        d_gnt, d_valid;
    logic [31:0] d_q;
    logic [9:0]  mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    logic [31:0] ram [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    mem_data_arbiter dut (
        .arb_in_clk          (clk),
        .arb_in_rst          (rst),
        .arb_in_p_req        (p_req),
        .arb_in_p_wren       (p_wren),
        .arb_in_p_addr       (p_addr),
        .arb_in_p_data       (p_data),
        .arb_out_p_gnt       (p_gnt),
        .arb_out_p_valid     (p_valid),
        .arb_out_p_q         (p_q),
        .arb_in_d_req        (d_req),
        .arb_in_d_addr       (d_addr),
`ifdef ARB_DEBUG_WRITE_EN
        .arb_in_d_wren       (d_wren),
        .arb_in_d_data       (d_data),
`endif
        .arb_out_d_gnt       (d_gnt),
        .arb_out_d_valid     (d_valid),
        .arb_out_d_q         (d_q),
        .arb_out_mem_address (mem_address),
        .arb_out_mem_data    (mem_data),
        .arb_out_mem_wren    (mem_wren),
        .arb_in_mem_q        (mem_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({p_gnt, d_gnt, p_valid, d_valid, mem_wren} !== 5'b0 ||
            p_q !== 32'h0 || d_q !== 32'h0 ||
            mem_address !== 10'h0 || mem_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: gnt=%b%b valid=%b%b wren=%b addr=%h want all 0",
                     p_gnt, d_gnt, p_valid, d_valid, mem_wren, mem_address);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic p_write(input logic [9:0] a, input logic [31:0] v);
        p_req = 1'b1; p_wren = 1'b1; p_addr = a; p_data = v;
        tick();
        p_req = 1'b0; p_wren = 1'b0;
        tick();
    endtask

    task automatic test_p_read();
        p_write(10'd5, 32'hDEADBEEF);
        p_req = 1'b1; p_addr = 10'd5;
        tick();
        n_cmp++;
        if (p_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_address !== 10'd5 ||
            mem_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL p_read_gnt: p_gnt=%b d_gnt=%b addr=%0d wren=%b want 1 0 5 0",
                     p_gnt, d_gnt, mem_address, mem_wren);
        end
        p_req = 1'b0;
        tick();
        n_cmp++;
        if (p_valid !== 1'b0 || p_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL p_read_early: valid=%b gnt=%b want 0 0", p_valid, p_gnt);
        end
        tick();
        n_cmp++;
        if (p_valid !== 1'b1 || p_q !== 32'hDEADBEEF || d_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL p_read_data: valid=%b q=%h d_valid=%b want 1 deadbeef 0",
                     p_valid, p_q, d_valid);
        end
        tick();
        n_cmp++;
        if (p_valid !== 1'b0 || p_q !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL p_read_hold: valid=%b q=%h want 0 deadbeef", p_valid, p_q);
        end
    endtask

    task automatic test_write_then_d_read();
        p_req = 1'b1; p_wren = 1'b1; p_addr = 10'd7; p_data = 32'h12345678;
        tick();
        n_cmp++;
        if (mem_wren !== 1'b1 || mem_data !== 32'h12345678 ||
            mem_address !== 10'd7 || p_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL write_issue: wren=%b data=%h addr=%0d gnt=%b want 1 12345678 7 1",
                     mem_wren, mem_data, mem_address, p_gnt);
        end
        p_req = 1'b0; p_wren = 1'b0;
        tick();
        n_cmp++;
        if (mem_wren !== 1'b0 || ram[7] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL write_done: wren=%b ram7=%h want 0 12345678", mem_wren, ram[7]);
        end
        d_req = 1'b1; d_addr = 10'd7;
        tick();
        n_cmp++;
        if (d_gnt !== 1'b1 || p_gnt !== 1'b0 || mem_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL d_read_gnt: d_gnt=%b p_gnt=%b wren=%b want 1 0 0",
                     d_gnt, p_gnt, mem_wren);
        end
        d_req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (d_valid !== 1'b1 || d_q !== 32'h12345678 || p_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL d_read_data: valid=%b q=%h p_valid=%b want 1 12345678 0",
                     d_valid, d_q, p_valid);
        end
        tick();
        n_cmp++;
        if (d_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL d_read_pulse: valid=%b want 0", d_valid);
        end
    endtask

    task automatic test_starvation();
        int waited;
        logic exp_d;
        int exp_cnt;
        p_req = 1'b1; p_addr = 10'd5;
        d_req = 1'b1; d_addr = 10'd7;
        for (int g = 0; g < 10; g++) begin
            waited = 0;
            do begin
                tick();
                waited++;
                if (p_gnt === 1'b1 && d_gnt === 1'b1) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL starve_dual_gnt: both grants high at grant %0d", g);
                end
            end while (p_gnt !== 1'b1 && d_gnt !== 1'b1 && waited < 6);
            exp_d   = (g == 4 || g == 9);
            exp_cnt = exp_d ? 0 : (g < 4 ? g + 1 : g - 4);
            n_cmp++;
            if (waited >= 6) begin
                n_bad++;
                $display("FAIL starve_timeout: no grant %0d within 6 cycles", g);
            end else if (d_gnt !== exp_d || p_gnt !== !exp_d ||
                         int'(dut.starve_cnt) != exp_cnt) begin
                n_bad++;
                $display("FAIL starve_order: grant %0d p=%b d=%b cnt=%0d want p=%b d=%b cnt=%0d",
                         g, p_gnt, d_gnt, dut.starve_cnt, !exp_d, exp_d, exp_cnt);
            end
        end
        p_req = 1'b0; d_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] seen;
        p_req = 1'b1; p_addr = 10'd5;
        tick();
        p_req = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({p_gnt, d_gnt, p_valid, d_valid, mem_wren} !== 5'b0 ||
            p_q !== 32'h0 || d_q !== 32'h0 ||
            mem_address !== 10'h0 || mem_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_async: valid=%b%b addr=%0d data=%h pq=%h want all 0",
                     p_valid, d_valid, mem_address, mem_data, p_q);
        end
        tick();
        rst = 1'b0;
        seen = 2'b00;
        repeat (3) begin
            tick();
            seen = seen | {p_valid, d_valid};
        end
        n_cmp++;
        if (seen !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_no_valid: seen valid=%b want 00", seen);
        end
        p_req = 1'b1; p_addr = 10'd7;
        tick();
        p_req = 1'b0;
        tick();
        n_cmp++;
        if (p_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_resume_early: valid=%b want 0", p_valid);
        end
        tick();
        n_cmp++;
        if (p_valid !== 1'b1 || p_q !== 32'h12345678) begin
            n_bad++;
            $display("FAIL reset_resume: valid=%b q=%h want 1 12345678", p_valid, p_q);
        end
        tick();
    endtask

    task automatic test_debug_write();
        logic [31:0] exp_q;
        logic        wr_seen;
        p_write(10'd3, 32'h0000005A);
        d_req = 1'b1; d_addr = 10'd3;
`ifdef ARB_DEBUG_WRITE_EN
        d_wren = 1'b1; d_data = 32'h000000A5;
        exp_q = 32'h000000A5;
`else
        exp_q = 32'h0000005A;
`endif
        tick();
        wr_seen = mem_wren;
        n_cmp++;
        if (d_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL dbg_gnt: d_gnt=%b want 1", d_gnt);
        end
        d_req = 1'b0;
`ifdef ARB_DEBUG_WRITE_EN
        d_wren = 1'b0;
        n_cmp++;
        if (wr_seen !== 1'b1 || mem_data !== 32'h000000A5) begin
            n_bad++;
            $display("FAIL dbg_write: wren=%b data=%h want 1 a5", wr_seen, mem_data);
        end
        tick();
        n_cmp++;
        if (ram[3] !== 32'h000000A5 || d_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dbg_write_ram: ram3=%h valid=%b want a5 0", ram[3], d_valid);
        end
        d_req = 1'b1;
        tick();
        d_req = 1'b0;
`else
        n_cmp++;
        if (wr_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL dbg_no_write: wren=%b want 0", wr_seen);
        end
`endif
        tick();
        tick();
        n_cmp++;
        if (d_valid !== 1'b1 || d_q !== exp_q || ram[3] !== exp_q) begin
            n_bad++;
            $display("FAIL dbg_read: valid=%b q=%h ram3=%h want 1 %h",
                     d_valid, d_q, ram[3], exp_q);
        end
        tick();
    endtask

    task automatic test_withdraw();
        logic [1:0] st;
        logic       dg_seen;
        p_req = 1'b1; p_addr = 10'd5;
        tick();
        p_req = 1'b0;
        d_req = 1'b1; d_addr = 10'd7;
        dg_seen = 1'b0;
        tick();
        d_req = 1'b0;
        dg_seen = dg_seen | d_gnt;
        tick();
        st = dut.state;
        dg_seen = dg_seen | d_gnt;
        n_cmp++;
        if (st !== 2'd3 || p_valid !== 1'b1 || p_q !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL withdraw_resp: state=%0d valid=%b q=%h want 3 1 deadbeef",
                     st, p_valid, p_q);
        end
        tick();
        st = dut.state;
        dg_seen = dg_seen | d_gnt;
        n_cmp++;
        if (st !== 2'd0) begin
            n_bad++;
            $display("FAIL withdraw_idle: state=%0d want 0", st);
        end
        repeat (3) begin
            tick();
            dg_seen = dg_seen | d_gnt;
        end
        n_cmp++;
        if (dg_seen !== 1'b0 || d_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL withdraw_no_gnt: d_gnt seen=%b d_valid=%b want 0 0",
                     dg_seen, d_valid);
        end
    endtask

    initial begin
        test_reset();
        test_p_read();
        test_write_then_d_read();
        test_starvation();
        test_reset_mid_read();
        test_debug_write();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
